// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial unsigned adder. Computes S = A + B one bit per
//               clock, LSB first, with a single full-adder cell and a carry
//               flip-flop. A start/busy/done handshake sequences each add.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N:0]   S,
    output logic         busy,
    output logic         done
);

    // Counter is at least one bit wide and reaches N-1 without wrapping.
    localparam int               c_CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [N-1:0]      r_ra;
    logic [N-1:0]      r_rb;
    logic [N-1:0]      r_result;
    logic [N-1:0]      w_result_next;
    logic              r_carry;
    logic [c_CW-1:0]   r_count;
    logic              w_s_bit;
    logic              w_carry_next;
    logic              w_last_step;

    // Single full-adder cell working on the current LSBs.
    assign w_s_bit      = r_ra[0] ^ r_rb[0] ^ r_carry;
    assign w_carry_next = (r_ra[0] & r_rb[0]) | (r_ra[0] & r_carry) | (r_rb[0] & r_carry);
    assign w_last_step  = (r_count == c_LAST);

    // Sum bits enter at the MSB so that after N steps the result is LSB-aligned.
    generate
        if (N == 1) begin : g_single_bit
            assign w_result_next = w_s_bit;
        end else begin : g_multi_bit
            assign w_result_next = {w_s_bit, r_result[N-1:1]};
        end
    endgenerate

    // State register; reset takes effect immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last_step) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand capture, serial add step and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ra     <= '0;
            r_rb     <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            S        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ra    <= A;
                        r_rb    <= B;
                        r_carry <= 1'b0;
                        r_count <= '0;
                    end
                end
                SHIFT: begin
                    r_ra     <= r_ra >> 1;
                    r_rb     <= r_rb >> 1;
                    r_carry  <= w_carry_next;
                    r_result <= w_result_next;
                    r_count  <= r_count + 1'b1;
                    // S only changes on completion; it holds between operations.
                    if (w_last_step) begin
                        S <= {w_carry_next, w_result_next};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder. Expected sums are
//               queued at each accepted start and compared when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int N      = 4;
    localparam int PERIOD = 10;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] A     = '0;
    logic [N-1:0] B     = '0;
    logic [N:0]   S;
    logic         busy;
    logic         done;

    typedef struct {
        logic [N:0] sum;
        time        t_acc;
    } exp_t;

    exp_t       sb_q[$];
    int         tests    = 0;
    int         fails    = 0;
    logic [N:0] last_s   = '0;
    int         busy_cnt = 0;

    serial_adder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .S     (S),
        .busy  (busy),
        .done  (done)
    );

    always #(PERIOD/2) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain unsigned addition widened by one bit.
    function automatic logic [N:0] ref_sum(input logic [N-1:0] a, input logic [N-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic push_exp(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        e.sum   = ref_sum(a, b);
        e.t_acc = $time;
        sb_q.push_back(e);
    endtask

    // One-cycle start from IDLE; returns at the negedge of the DONE cycle.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        start = 1'b1;
        A     = a;
        B     = b;
        @(posedge clk);
        push_exp(a, b);
        @(negedge clk);
        start = 1'b0;
        A     = N'($urandom);
        B     = N'($urandom);
        repeat (N) @(negedge clk);
    endtask

    // start held high: each accepting edge captures its own operands.
    task automatic run_held(input int cnt);
        @(negedge clk);
        start = 1'b1;
        A     = N'($urandom);
        B     = N'($urandom);
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk);
            push_exp(A, B);
            @(negedge clk);
            A = N'($urandom);
            B = N'($urandom);
            repeat (N + 1) @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: compares on done, tracks busy length and S hold behaviour.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_S", 32'(S), 32'd0);
                check("reset_busy", 32'(busy), 32'd0);
                check("reset_done", 32'(done), 32'd0);
                busy_cnt = 0;
                last_s   = '0;
            end else begin
                if (busy && done) begin
                    check("busy_and_done", 32'(busy & done), 32'd0);
                end
                if (busy) begin
                    busy_cnt++;
                end
                if (done) begin
                    if (sb_q.size() == 0) begin
                        check("spurious_done", 32'(done), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("sum", 32'(S), 32'(e.sum));
                        check("latency", 32'($time - e.t_acc), 32'(N*PERIOD + PERIOD/2));
                        check("busy_cycles", 32'(busy_cnt), 32'(N));
                        last_s = e.sum;
                    end
                    busy_cnt = 0;
                end else begin
                    check("S_hold", 32'(S), 32'(last_s));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset values are visible immediately.
        rst_n = 1'b0;
        #1;
        check("por_S", 32'(S), 32'd0);
        check("por_busy", 32'(busy), 32'd0);
        check("por_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        issue(4'b0011, 4'b0010);
        issue(4'b1001, 4'b0110);
        issue(4'b1111, 4'b1111);
        issue(4'b0000, 4'b0000);

        // Overlapping start in SHIFT is ignored.
        @(negedge clk);
        start = 1'b1;
        A     = 4'b0101;
        B     = 4'b0001;
        @(posedge clk);
        push_exp(4'b0101, 4'b0001);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        A     = 4'b1111;
        B     = 4'b1111;
        @(negedge clk);
        start = 1'b0;
        repeat (N - 2) @(negedge clk);

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1;
        A     = 4'b1000;
        B     = 4'b1000;
        @(posedge clk);
        push_exp(4'b1000, 4'b1000);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        check("midop_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("abort_S", 32'(S), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 3) @(negedge clk);
        issue(4'b0001, 4'b0001);

        // Randomized operations with random idle gaps.
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(N'($urandom), N'($urandom));
        end

        // Back-to-back operations with start held high.
        run_held(4);

        // Drain any outstanding expectation within a bounded window.
        for (int i = 0; i < N + 6 && sb_q.size() != 0; i++) begin
            @(negedge clk);
        end
        check("drain", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial unsigned adder: computes S = A + B one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop. It is the additive counterpart of the combinational A − B subtractor. It recovers A from a difference and B, or accumulates operands, where area matters more than latency. It uses a start/busy/done handshake for a sequencing controller.

## Interface
- n, default 4: operand width in bits; must be ≥ 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; takes effect immediately on assertion and is released synchronously by the design that drives it.
- start  input  1  request; sampled on the rising edge, honoured only in IDLE.
- A  input  n  augend; captured on the edge that accepts start.
- B  input  n  addend; captured on the edge that accepts start.
- S  output  n+1  unsigned sum {carry_out, sum[n-1:0]}; registered.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; S is valid in this cycle.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE behaviour:
  - start = 1 → load shift registers ra <= A and rb <= B.
  - carry <= 0, bit counter <= 0.
  - Go to SHIFT.
  - start = 0 → stay in IDLE.
- SHIFT step, one per edge:
  - s_bit = ra[0] ^ rb[0] ^ carry.
  - carry <= majority(ra[0], rb[0], carry).
  - ra and rb shift right by 1.
  - s_bit shifts into the MSB of the result register, so after n steps result[n-1:0] holds the sum LSB-aligned.
  - The counter increments on each step.
- On the n-th step (counter = n−1):
  - S <= {carry_next, result_next}.
  - Go to DONE.
- DONE: lasts exactly one cycle, then unconditionally returns to IDLE.
- start outside IDLE (SHIFT or DONE): ignored. It is not queued, and A and B are not re-sampled.
- A and B may change freely after the accepting edge without affecting the result.
- S holds its value from DONE until the next completion. It is not cleared on start.
- Arithmetic: unsigned, no overflow. S[n] is the carry-out. Maximum result is 2·(2^n − 1), which fits in n+1 bits.
- Counter width is clog2(n) bits, minimum 1. It must not wrap before n steps complete.

## Timing
- Reset values: S = 0, busy = 0, done = 0. State = IDLE, carry = 0, counter = 0.
- Let start be accepted on edge k.
- busy is high from edge k until edge k+n, i.e. for exactly n cycles.
- done is high and S is valid for the single cycle after edge k+n. busy is 0 in that cycle.
- Latency from accepting edge to done is n cycles.
- Throughput: one operation per n+2 cycles. The earliest next accepted start is edge k+n+2, since the DONE cycle ignores start.
- busy and done are never high in the same cycle.
- Reset asserted mid-operation:
  - All outputs and state return to reset values immediately, without waiting for a clock edge.
  - The partial result is discarded.
  - No done pulse is produced for the aborted operation.
- start held high continuously: operations run back-to-back every n+2 cycles, each capturing A and B at its own accepting edge.

## Test plan
- n = 4, A = 0011, B = 0010, one-cycle start:
  - busy high for 4 cycles.
  - Then done pulse with S = 00101.
  - S holds 00101 afterwards.
- A = 1001, B = 0110 → S = 01111.
- A = 1111, B = 1111 → S = 11110 (carry-out set).
- A = 0000, B = 0000 → S = 00000, with done at exactly 4 cycles after start.
- Overlapping start:
  - A = 0101, B = 0001 is accepted.
  - Two cycles later, start with A = 1111, B = 1111.
  - Required: the second start is ignored and the result is S = 00110.
  - One done pulse only.
- Reset mid-operation:
  - Start A = 1000, B = 1000, then assert rst_n = 0 after 2 busy cycles.
  - Required: S, busy and done go to 0 immediately, and no done pulse follows.
  - A fresh start afterwards with A = 0001, B = 0001 → S = 00010.
